// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IR, one-outstanding-read fetch FSM, halt/fault status.
// Optional: define FETCH_WRAP_TRAP_EN to make a PC wrap by increment/skip a sticky fault.
module fetch_unit #(
    parameter int OPC_W  = 3,
    parameter int ADDR_W = 5,
    parameter int INS_W  = OPC_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic              pc_load,
    input  logic              jmp,
    input  logic              halt,
    input  logic              memIns_en,
    output logic              ins_re,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic [INS_W-1:0]  ins_rdata,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_valid,
    output logic              halted,
    output logic              pc_fault
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [INS_W-1:0]  ir;
    logic [INS_W-1:0]  ir_nx;
    logic              ir_valid_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [ADDR_W-1:0] step;
    logic              frozen;

    assign frozen   = halted | pc_fault;
    assign opcode   = ir[INS_W-1 -: OPC_W];
    assign operand  = ir[ADDR_W-1:0];
    assign ins_addr = rst ? '0 : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ir       <= '0;
            ir_valid <= 1'b0;
            pc       <= '0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nx;
            ir       <= ir_nx;
            ir_valid <= ir_valid_nx;
            pc       <= pc_nx;
            halted   <= halted | halt;
        end
    end

    // A read already in WAIT always lands in IR, even once frozen.
    always_comb begin
        state_nx    = state;
        ins_re      = 1'b0;
        ir_nx       = ir;
        ir_valid_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (memIns_en && !frozen && !rst) begin
                    ins_re   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                ir_nx       = ins_rdata;
                ir_valid_nx = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pc_nx = pc;
        step  = pc_load ? ADDR_W'(2) : ADDR_W'(1);
        if (!frozen) begin
            if (pc_load && jmp) begin
                pc_nx = operand;
            end else if (pc_load || pc_en) begin
                pc_nx = pc + step;
            end
        end
    end

`ifdef FETCH_WRAP_TRAP_EN
    logic seq_upd;
    logic wrap;

    assign seq_upd = !frozen && (pc_load ? !jmp : pc_en);
    assign wrap    = seq_upd && (pc_nx < pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_fault <= 1'b0;
        end else begin
            pc_fault <= pc_fault | wrap;
        end
    end
`else
    assign pc_fault = 1'b0;
`endif

endmodule
